// File: rtl/axis_pingpong_router_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pingpong_router_if
//  Purpose  : AXI-stream bundle (tdata/tlast/tvalid/tready) used by the
//             ping-pong router for its upstream and downstream sides.
//  Ports    : none; the signals are reached through the modports.
//             master - drives tdata/tlast/tvalid, samples tready
//             slave  - samples tdata/tlast/tvalid, drives tready
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_pingpong_router_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_pingpong_router.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pingpong_router
//  Purpose  : Inline AXI-stream stage ahead of an axis_switch. The stream
//             passes through with zero latency. port_select chooses the
//             ping-pong buffer being filled. Each buffer takes PKTS_PER_BUF
//             packets, or fewer when flushed, and is then handed to the
//             consumer. The stream stalls while the next buffer is still
//             owned by the consumer.
//  Ports    : clk, reset      - clock, asynchronous active-high reset
//             axis_in         - upstream stream (slave side)
//             axis_out        - stream towards the switch (master side)
//             port_select     - buffer currently being filled
//             flush           - strobe: hand off the partial buffer at the
//                               next packet end
//             buf_release[i]  - strobe: consumer has drained buffer i
//             buf_done[i]     - strobe: buffer i handed to the consumer
//             done_count      - packet count of the handed-off buffer
//  Revision : 1.0 - initial release
// ============================================================================
module axis_pingpong_router #(
  parameter  int DW           = 512,
  parameter  int PKTS_PER_BUF = 256,
  localparam int CW           = $clog2(PKTS_PER_BUF + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  axis_pingpong_router_if.slave  axis_in,
  axis_pingpong_router_if.master axis_out,
  output logic                   port_select,
  input  logic                   flush,
  input  logic [1:0]             buf_release,
  output logic [1:0]             buf_done,
  output logic [CW-1:0]          done_count
);

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,
    S_FILL = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_pkts_per_buf = CW'(PKTS_PER_BUF);

  state_t        r_state,      w_state_nxt;
  logic          r_cur,        w_cur_nxt;
  logic [1:0]    r_avail,      w_avail_nxt;
  logic [CW-1:0] r_pkt_cnt,    w_pkt_cnt_nxt;
  logic          r_in_pkt,     w_in_pkt_nxt;
  logic          r_flush_pend, w_flush_pend_nxt;
  logic [1:0]    r_buf_done,   w_buf_done_nxt;
  logic [CW-1:0] r_done_count, w_done_count_nxt;

  logic          w_fill;
  logic          w_beat;
  logic          w_last_beat;
  logic [CW-1:0] w_n;
  logic          w_empty;
  logic          w_flush_eff;
  logic          w_handoff;
  logic [DW-1:0] w_tdata;

  // Data and tlast are never gated; only the handshake depends on state.
  assign w_tdata         = axis_in.tdata;
  assign axis_out.tdata  = w_tdata;
  assign axis_out.tlast  = axis_in.tlast;
  assign w_fill          = (r_state == S_FILL);
  assign axis_out.tvalid = w_fill & axis_in.tvalid;
  assign axis_in.tready  = w_fill & axis_out.tready;

  assign port_select = r_cur;
  assign buf_done    = r_buf_done;
  assign done_count  = r_done_count;

  always_comb begin
    w_beat      = w_fill & axis_in.tvalid & axis_out.tready;
    w_last_beat = w_beat & axis_in.tlast;
    w_n         = r_pkt_cnt + 1'b1;
    // A beat accepted in the flush cycle makes the buffer non-empty, so a
    // flush coinciding with the first beat of a buffer still takes effect.
    w_empty     = (r_pkt_cnt == '0) & ~r_in_pkt & ~w_beat;
    w_flush_eff = flush & ~w_empty;
    w_handoff   = w_last_beat &
                  ((w_n == c_pkts_per_buf) | r_flush_pend | w_flush_eff);

    w_state_nxt      = r_state;
    w_cur_nxt        = r_cur;
    w_avail_nxt      = r_avail | buf_release;
    w_pkt_cnt_nxt    = r_pkt_cnt;
    w_in_pkt_nxt     = r_in_pkt;
    w_flush_pend_nxt = r_flush_pend | w_flush_eff;
    w_buf_done_nxt   = 2'b00;
    w_done_count_nxt = '0;

    case (r_state)
      S_WAIT: if (r_avail[r_cur]) w_state_nxt = S_FILL;
      S_FILL: if (w_handoff)      w_state_nxt = S_WAIT;
      default:                    w_state_nxt = S_WAIT;
    endcase

    if (w_beat) w_in_pkt_nxt = ~axis_in.tlast;

    if (w_last_beat) w_pkt_cnt_nxt = w_n;

    if (w_handoff) begin
      // The hand-off overrides a release of the same buffer this cycle.
      w_avail_nxt[r_cur] = 1'b0;
      w_cur_nxt          = ~r_cur;
      w_pkt_cnt_nxt      = '0;
      w_flush_pend_nxt   = 1'b0;
      w_buf_done_nxt     = r_cur ? 2'b10 : 2'b01;
      w_done_count_nxt   = w_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_cur        <= 1'b0;
      r_avail      <= 2'b11;
      r_pkt_cnt    <= '0;
      r_in_pkt     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_buf_done   <= 2'b00;
      r_done_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= w_cur_nxt;
      r_avail      <= w_avail_nxt;
      r_pkt_cnt    <= w_pkt_cnt_nxt;
      r_in_pkt     <= w_in_pkt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_buf_done   <= w_buf_done_nxt;
      r_done_count <= w_done_count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pingpong_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pingpong_router
//  Purpose  : Self-checking bench for axis_pingpong_router with
//             PKTS_PER_BUF=4: a cycle table, directed flush/reset
//             sequences and a randomized run against a packet-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pingpong_router;
  localparam int DW  = 32;
  localparam int PPB = 4;
  localparam int CW  = $clog2(PPB + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          port_select;
  logic          flush;
  logic [1:0]    buf_release;
  logic [1:0]    buf_done;
  logic [CW-1:0] done_count;

  axis_pingpong_router_if #(.DW(DW)) axis_in ();
  axis_pingpong_router_if #(.DW(DW)) axis_out ();

  axis_pingpong_router #(.DW(DW), .PKTS_PER_BUF(PPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .axis_in     (axis_in),
    .axis_out    (axis_out),
    .port_select (port_select),
    .flush       (flush),
    .buf_release (buf_release),
    .buf_done    (buf_done),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          tv, tr, tl;
    logic [1:0]    rel;
    logic          e_itr, e_otv, e_ps;
    logic [1:0]    e_bd;
    logic [CW-1:0] e_dc;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic tv, logic tr, logic tl, logic [1:0] rel,
                              logic itr, logic otv, logic ps, logic [1:0] bd, int dc);
    vec_t v;
    v.tv = tv; v.tr = tr; v.tl = tl; v.rel = rel;
    v.e_itr = itr; v.e_otv = otv; v.e_ps = ps; v.e_bd = bd; v.e_dc = CW'(dc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    axis_in.tvalid  = 1'b0;
    axis_in.tlast   = 1'b0;
    axis_in.tdata   = '0;
    axis_out.tready = 1'b1;
    flush           = 1'b0;
    buf_release     = 2'b00;
  endtask

  // Presents one beat and holds it until accepted; flush stays up with it.
  task automatic send_beat(input logic last, input logic fl, input logic exp_ps, input string tag);
    bit ok = 0;
    axis_in.tvalid  = 1'b1;
    axis_in.tlast   = last;
    axis_in.tdata   = $urandom();
    axis_out.tready = 1'b1;
    flush           = fl;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (axis_in.tready === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: beat not accepted within 50 cycles", tag);
    end else begin
      chk({tag, " port_select"}, port_select, exp_ps);
    end
    @(posedge clk); #1;
    axis_in.tvalid = 1'b0;
    axis_in.tlast  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] bd, input int dc);
    chk({tag, " buf_done"}, buf_done, bd);
    chk({tag, " done_count"}, done_count, 64'(dc));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          in_hs, out_hs, exp_port;
    logic [1:0]    rel, exp_bd;
    logic [CW-1:0] exp_dc;
    logic [DW-1:0] b_data;
    logic          b_last;
    bit            have_beat;
    bit            owned[2];
    int            tmr[2];
    int            k_out, rem;

    // ---------------- reset values ----------------
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_tready", axis_in.tready, 1'b0);
    chk("rst out_tvalid", axis_out.tvalid, 1'b0);
    chk("rst port_select", port_select, 1'b0);
    chk_regs("rst", 2'b00, 0);

    // ---------------- cycle table: fill both buffers, then release ----------------
    vt[0] = mk(1, 1, 1, 2'b00, 0, 0, 0, 2'b00, 0);
    for (int i = 1; i <= 4; i++) vt[i] = mk(1, 1, 1, 2'b00, 1, 1, 0, 2'b00, 0);
    vt[5] = mk(1, 1, 1, 2'b00, 0, 0, 1, 2'b01, 4);
    for (int i = 6; i <= 9; i++) vt[i] = mk(1, 1, 1, 2'b00, 1, 1, 1, 2'b00, 0);
    vt[10] = mk(1, 1, 1, 2'b00, 0, 0, 0, 2'b10, 4);
    vt[11] = mk(1, 1, 1, 2'b01, 0, 0, 0, 2'b00, 0);
    vt[12] = mk(1, 1, 1, 2'b00, 0, 0, 0, 2'b00, 0);
    vt[13] = mk(1, 1, 1, 2'b00, 1, 1, 0, 2'b00, 0);
    vt[14] = mk(0, 1, 0, 2'b00, 1, 0, 0, 2'b00, 0);
    vt[15] = mk(1, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0);

    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      axis_in.tvalid  = vt[i].tv;
      axis_in.tlast   = vt[i].tl;
      axis_in.tdata   = $urandom();
      axis_out.tready = vt[i].tr;
      buf_release     = vt[i].rel;
      #1;
      chk($sformatf("vec%0d in_tready", i), axis_in.tready, vt[i].e_itr);
      chk($sformatf("vec%0d out_tvalid", i), axis_out.tvalid, vt[i].e_otv);
      chk($sformatf("vec%0d port_select", i), port_select, vt[i].e_ps);
      chk($sformatf("vec%0d tdata", i), axis_out.tdata, axis_in.tdata);
      chk($sformatf("vec%0d tlast", i), axis_out.tlast, vt[i].tl);
      chk_regs($sformatf("vec%0d", i), vt[i].e_bd, int'(vt[i].e_dc));
      @(posedge clk); #1;
    end
    idle();

    // ---------------- flush mid-packet (buffer 0 already holds one packet) ----------------
    send_beat(1'b0, 1'b1, 1'b0, "flush b1");
    send_beat(1'b0, 1'b0, 1'b0, "flush b2");
    send_beat(1'b1, 1'b0, 1'b0, "flush b3");
    chk_regs("flush handoff", 2'b01, 2);
    chk("flush port after", port_select, 1'b1);
    @(posedge clk); #1;
    chk_regs("flush done clear", 2'b00, 0);
    chk("both owned stall", axis_in.tready, 1'b0);

    // ---------------- flush on an empty buffer is discarded ----------------
    buf_release = 2'b11;
    @(posedge clk); #1;
    buf_release = 2'b00;
    @(posedge clk); #1;
    chk("empty flush port", port_select, 1'b1);
    chk("empty flush ready", axis_in.tready, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_regs($sformatf("empty flush idle%0d", i), 2'b00, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      send_beat(1'b1, 1'b0, 1'b1, $sformatf("post flush pkt%0d", i));
      if (i < 3) chk_regs($sformatf("post flush pkt%0d", i), 2'b00, 0);
    end
    chk_regs("post flush handoff", 2'b10, 4);

    // Fill buffer 0 so that buffer 1 is being filled when reset hits.
    for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b0, 1'b0, $sformatf("fill0 pkt%0d", i));
    chk_regs("fill0 handoff", 2'b01, 4);
    buf_release = 2'b10;
    @(posedge clk); #1;
    buf_release = 2'b00;

    // ---------------- reset mid-packet ----------------
    send_beat(1'b0, 1'b0, 1'b1, "midrst b1");
    send_beat(1'b0, 1'b0, 1'b1, "midrst b2");
    axis_in.tvalid = 1'b1;
    axis_in.tlast  = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst in_tready", axis_in.tready, 1'b0);
    chk("midrst out_tvalid", axis_out.tvalid, 1'b0);
    chk("midrst port_select", port_select, 1'b0);
    chk_regs("midrst", 2'b00, 0);
    axis_in.tvalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    send_beat(1'b1, 1'b1, 1'b0, "after rst pkt");
    chk_regs("after rst", 2'b01, 1);

    // ---------------- randomized run against a packet-level model ----------------
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    k_out = 0; rem = 0; have_beat = 0; b_data = '0; b_last = 1'b0;
    owned[0] = 0; owned[1] = 0; tmr[0] = 0; tmr[1] = 0;
    exp_bd = 2'b00; exp_dc = '0;
    for (int cyc = 0; cyc < 60000 && k_out < 1000; cyc++) begin
      chk("rnd buf_done", buf_done, exp_bd);
      chk("rnd done_count", done_count, exp_dc);
      exp_bd = 2'b00;
      exp_dc = '0;
      rel = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (owned[p]) begin
          if (tmr[p] == 0) begin rel[p] = 1'b1; owned[p] = 0; end
          else tmr[p]--;
        end else if ($urandom_range(0, 7) == 0) begin
          rel[p] = 1'b1;
        end
      end
      buf_release = rel;
      if (!have_beat && $urandom_range(0, 3) != 0) begin
        if (rem == 0) rem = $urandom_range(1, 4);
        have_beat = 1;
        b_data = $urandom();
        b_last = (rem == 1);
      end
      axis_in.tvalid  = have_beat;
      axis_in.tdata   = b_data;
      axis_in.tlast   = b_last;
      axis_out.tready = ($urandom_range(0, 3) != 0);
      #1;
      in_hs  = axis_in.tvalid & axis_in.tready;
      out_hs = axis_out.tvalid & axis_out.tready;
      chk("rnd handshake", out_hs, in_hs);
      if (out_hs) begin
        exp_port = 1'((k_out / PPB) % 2);
        chk("rnd port", port_select, exp_port);
        chk("rnd tdata", axis_out.tdata, b_data);
        chk("rnd tlast", axis_out.tlast, b_last);
        chk("rnd target free", owned[port_select], 1'b0);
        if (b_last) begin
          k_out++;
          if (k_out % PPB == 0) begin
            exp_bd = exp_port ? 2'b10 : 2'b01;
            exp_dc = CW'(PPB);
            owned[exp_port] = 1;
            tmr[exp_port] = $urandom_range(0, 30);
          end
        end
      end
      if (in_hs) begin
        have_beat = 0;
        rem--;
      end
      @(posedge clk); #1;
    end
    chk("rnd packets delivered", 64'(k_out), 64'd1000);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
